serial_route_tx: RTL and testbench

Upstream feeder for the 1-to-2 serial demultiplexer. It accepts parallel words with a 1-bit destination tag over a valid/ready handshake and serializes each word MSB-first onto the demux data line `y`. It drives the demux select `es` from the tag and holds `es` stable for the whole frame plus the inter-word gap, so the demux never sees a select change mid-word. Also provides frame/done status for the downstream collector.

---
 rtl/serial_route_tx.sv | 133 +++++++++++++
 tb/tb_serial_route_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_route_tx.sv
// serial_route_tx: upstream feeder for a 1-to-2 serial demultiplexer.
//
// Accepts a parallel word plus a 1-bit destination tag over valid/ready and
// shifts the word out MSB-first on y. The demux select es is captured with the
// word and held through the whole frame and the following idle gap, so the
// demux never sees a select change mid-word.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_data   parallel word to send (WIDTH bits)
//   in_dest   destination tag: 0 = demux output A, 1 = demux output B
//   in_valid  in_data/in_dest valid
//   in_ready  block can accept a word this cycle (state register decode only)
//   y         serial data to the demux data input
//   es        select to the demux control input
//   frame     high while y carries a data bit
//   busy      high whenever not idle
//   done      one-cycle pulse in the cycle after the last data bit
module serial_route_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dest,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             y,
    output logic             es,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
    localparam logic [GapW-1:0] GapLast = GapW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BitW-1:0]   bitcnt_q, bitcnt_d;
    logic [GapW-1:0]   gapcnt_q, gapcnt_d;
    logic              es_q, es_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            es_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            es_q     <= es_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        es_d     = es_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // in_ready is implied by being in this state.
                if (in_valid) begin
                    shreg_d  = in_data;
                    es_d     = in_dest;
                    bitcnt_d = '0;
                    state_d  = StShift;
                end
            end

            StShift: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (bitcnt_q == BitLast) begin
                    done_d   = 1'b1;
                    bitcnt_d = '0;
                    if (IDLE_GAP > 0) begin
                        gapcnt_d = '0;
                        state_d  = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end

            StGap: begin
                if (gapcnt_q == GapLast) begin
                    gapcnt_d = '0;
                    state_d  = StIdle;
                end else begin
                    gapcnt_d = gapcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q != StIdle);
        frame    = (state_q == StShift);
        y        = frame & shreg_q[WIDTH-1];
        es       = es_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_serial_route_tx.sv
// Directed bench for serial_route_tx: one instance with the default gap and
// one built with IDLE_GAP=0. Outputs are sampled 1 time unit after the rising
// edge; inputs are driven at the same point.
module tb_serial_route_tx;

    logic       clk;
    logic       rst_n;

    logic [7:0] in_data;
    logic       in_dest;
    logic       in_valid;
    logic       in_ready, y, es, frame, busy, done;

    logic [7:0] z_data;
    logic       z_dest;
    logic       z_valid;
    logic       z_ready, z_y, z_es, z_frame, z_busy, z_done;

    int n_cmp;
    int n_err;

    serial_route_tx #(
        .WIDTH    (8),
        .IDLE_GAP (2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .es       (es),
        .frame    (frame),
        .busy     (busy),
        .done     (done)
    );

    serial_route_tx #(
        .WIDTH    (8),
        .IDLE_GAP (0)
    ) u_dut_nogap (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (z_data),
        .in_dest  (z_dest),
        .in_valid (z_valid),
        .in_ready (z_ready),
        .y        (z_y),
        .es       (z_es),
        .frame    (z_frame),
        .busy     (z_busy),
        .done     (z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the 8 frame cycles of the default instance, starting in frame cycle 0.
    task automatic run_frame(input string tag, input logic [7:0] w, input logic exp_es);
        for (int b = 0; b < 8; b++) begin
            chk({tag, "_y"}, y, w[7-b]);
            chk({tag, "_es"}, es, exp_es);
            chk({tag, "_frame"}, frame, 1'b1);
            chk({tag, "_ready"}, in_ready, 1'b0);
            chk({tag, "_done"}, done, 1'b0);
            step();
        end
    endtask

    // From the cycle after the last data bit: done pulse, two gap cycles, idle.
    task automatic run_tail(input string tag, input logic exp_es);
        chk({tag, "_done_hi"}, done, 1'b1);
        chk({tag, "_gap1_y"}, y, 1'b0);
        chk({tag, "_gap1_frame"}, frame, 1'b0);
        chk({tag, "_gap1_busy"}, busy, 1'b1);
        chk({tag, "_gap1_ready"}, in_ready, 1'b0);
        chk({tag, "_gap1_es"}, es, exp_es);
        step();
        chk({tag, "_gap2_done"}, done, 1'b0);
        chk({tag, "_gap2_y"}, y, 1'b0);
        chk({tag, "_gap2_ready"}, in_ready, 1'b0);
        chk({tag, "_gap2_es"}, es, exp_es);
        step();
        chk({tag, "_idle_ready"}, in_ready, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_es"}, es, exp_es);
    endtask

    initial begin
        logic [7:0] w;
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        in_data  = 8'h00;
        in_dest  = 1'b0;
        in_valid = 1'b0;
        z_data   = 8'h00;
        z_dest   = 1'b0;
        z_valid  = 1'b0;

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_y", y, 1'b0);
        chk("rst_es", es, 1'b0);
        chk("rst_frame", frame, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_z_ready", z_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single word 0xA5 to A.
        in_data  = 8'hA5;
        in_dest  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run_frame("single", 8'hA5, 1'b0);
        run_tail("single", 1'b0);

        // Back-to-back: 0xFF to B, then 0x01 to A with valid held high.
        in_data  = 8'hFF;
        in_dest  = 1'b1;
        in_valid = 1'b1;
        step();
        in_data = 8'h01;
        in_dest = 1'b0;
        run_frame("b2b1", 8'hFF, 1'b1);
        chk("b2b1_done", done, 1'b1);
        chk("b2b1_gap_es", es, 1'b1);
        step();
        chk("b2b1_gap2_es", es, 1'b1);
        chk("b2b1_gap2_ready", in_ready, 1'b0);
        step();
        // 11th cycle after accept: idle, second accept happens at this edge.
        chk("b2b_idle_ready", in_ready, 1'b1);
        chk("b2b_idle_es_hold", es, 1'b1);
        step();
        in_valid = 1'b0;
        run_frame("b2b2", 8'h01, 1'b0);
        run_tail("b2b2", 1'b0);

        // Stalled input: changes while in_ready=0 must not disturb the frame.
        in_data  = 8'hA5;
        in_dest  = 1'b0;
        in_valid = 1'b1;
        step();
        in_data = 8'h3C;
        in_dest = 1'b1;
        run_frame("stall", 8'hA5, 1'b0);
        in_valid = 1'b0;
        run_tail("stall", 1'b0);

        // Reset mid-frame after bit 3 of 0xA5.
        in_data  = 8'hA5;
        in_dest  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        w = 8'hA5;
        for (int b = 0; b < 4; b++) begin
            chk("midrst_pre_y", y, w[7-b]);
            step();
        end
        chk("midrst_still_frame", frame, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_y", y, 1'b0);
        chk("midrst_frame", frame, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        step();
        chk("midrst_no_done1", done, 1'b0);
        step();
        chk("midrst_no_done2", done, 1'b0);
        rst_n = 1'b1;
        chk("midrst_rel_ready", in_ready, 1'b1);
        in_data  = 8'h81;
        in_dest  = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run_frame("post", 8'h81, 1'b1);
        run_tail("post", 1'b1);

        // IDLE_GAP=0 build: accepts 9 cycles apart, no gap state.
        z_data  = 8'h96;
        z_dest  = 1'b1;
        z_valid = 1'b1;
        step();
        z_data = 8'h5A;
        z_dest = 1'b0;
        w = 8'h96;
        for (int b = 0; b < 8; b++) begin
            chk("nogap1_y", z_y, w[7-b]);
            chk("nogap1_es", z_es, 1'b1);
            chk("nogap1_frame", z_frame, 1'b1);
            chk("nogap1_done", z_done, 1'b0);
            step();
        end
        chk("nogap_done_hi", z_done, 1'b1);
        chk("nogap_ready", z_ready, 1'b1);
        chk("nogap_busy", z_busy, 1'b0);
        chk("nogap_y", z_y, 1'b0);
        chk("nogap_es_hold", z_es, 1'b1);
        step();
        z_valid = 1'b0;
        w = 8'h5A;
        for (int b = 0; b < 8; b++) begin
            chk("nogap2_y", z_y, w[7-b]);
            chk("nogap2_es", z_es, 1'b0);
            chk("nogap2_frame", z_frame, 1'b1);
            chk("nogap2_done", z_done, 1'b0);
            step();
        end
        chk("nogap2_done_hi", z_done, 1'b1);
        step();
        chk("nogap2_done_lo", z_done, 1'b0);
        chk("nogap2_idle_ready", z_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
